// File: rtl/dr_memory.sv
// dr_memory: dual-rail (10 = 1, 01 = 0, 00 = spacer, 11 = illegal) single-port
// memory with four-phase handshakes on reads and writes.
//   clk, rst_n         : clock, asynchronous active-low reset
//   addr, read_Nwrite,
//   data_in            : dual-rail request inputs, sampled into S1 then S2
//   ack_in_read        : consumer acknowledge of read data
//   data_out, ack_read : registered dual-rail read data and read acknowledge
//   ack_write          : registered write acknowledge
//   error              : sticky flag, set when an illegal codeword settles
module dr_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [1:0]            read_Nwrite,
  input  logic [2*DATA_W-1:0]   data_in,
  input  logic                  ack_in_read,
  output logic [2*DATA_W-1:0]   data_out,
  output logic                  ack_read,
  output logic                  ack_write,
  output logic                  error
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int IN_W  = 2*ADDR_W + 2 + 2*DATA_W;

  typedef enum logic [2:0] {IDLE, RD_ACK, RD_RTZ, WR_ACK, ERR} state_t;

  state_t state_q, state_d;
  logic [IN_W-1:0]     s1_q, s1_d, s2_q, s2_d;
  logic [2*DATA_W-1:0] data_out_q, data_out_d;
  logic                ack_read_q, ack_read_d;
  logic                ack_write_q, ack_write_d;
  logic                error_q, error_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;

  // Unpacked views of the two sample stages
  logic [2*ADDR_W-1:0] s1_addr, s2_addr;
  logic [1:0]          s1_rnw, s2_rnw;
  logic [2*DATA_W-1:0] s1_data, s2_data;

  assign s1_addr = s1_q[IN_W-1 -: 2*ADDR_W];
  assign s2_addr = s2_q[IN_W-1 -: 2*ADDR_W];
  assign s1_rnw  = s1_q[2*DATA_W +: 2];
  assign s2_rnw  = s2_q[2*DATA_W +: 2];
  assign s1_data = s1_q[2*DATA_W-1:0];
  assign s2_data = s2_q[2*DATA_W-1:0];

  assign s1_d = {addr, read_Nwrite, data_in};
  assign s2_d = s1_q;

  // Per-pair classification of S1; spacer checks require both stages
  logic              addr_cmpl, addr_ill, addr_sp;
  logic              data_cmpl, data_ill, data_sp;
  logic [ADDR_W-1:0] addr_val;
  logic [DATA_W-1:0] data_val;

  always_comb begin
    addr_cmpl = 1'b1;
    addr_ill  = 1'b0;
    addr_sp   = 1'b1;
    addr_val  = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      addr_cmpl   &= (s1_addr[2*i +: 2] == 2'b01) || (s1_addr[2*i +: 2] == 2'b10);
      addr_ill    |= (s1_addr[2*i +: 2] == 2'b11);
      addr_sp     &= (s1_addr[2*i +: 2] == 2'b00) && (s2_addr[2*i +: 2] == 2'b00);
      addr_val[i]  = s1_addr[2*i+1];
    end
    data_cmpl = 1'b1;
    data_ill  = 1'b0;
    data_sp   = 1'b1;
    data_val  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data_cmpl   &= (s1_data[2*i +: 2] == 2'b01) || (s1_data[2*i +: 2] == 2'b10);
      data_ill    |= (s1_data[2*i +: 2] == 2'b11);
      data_sp     &= (s1_data[2*i +: 2] == 2'b00) && (s2_data[2*i +: 2] == 2'b00);
      data_val[i]  = s1_data[2*i+1];
    end
  end

  logic stable, rnw_sp, is_rd, is_wr, go_err, go_rd, go_wr;
  assign stable = (s1_q == s2_q);
  assign rnw_sp = (s1_rnw == 2'b00) && (s2_rnw == 2'b00);
  assign is_rd  = (s1_rnw == 2'b10);
  assign is_wr  = (s1_rnw == 2'b01);
  // data_in only matters for legality when the operation is a write
  assign go_err = stable && (addr_ill || (s1_rnw == 2'b11) || (is_wr && data_ill));
  assign go_rd  = stable && !go_err && addr_cmpl && is_rd;
  assign go_wr  = stable && !go_err && addr_cmpl && is_wr && data_cmpl;

  // Dual-rail encoding of the addressed word
  logic [DATA_W-1:0]   rd_word;
  logic [2*DATA_W-1:0] rd_enc;
  assign rd_word = mem_q[addr_val];
  always_comb begin
    rd_enc = '0;
    for (int i = 0; i < DATA_W; i++) rd_enc[2*i +: 2] = rd_word[i] ? 2'b10 : 2'b01;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s1_q        <= '0;
      s2_q        <= '0;
      data_out_q  <= '0;
      ack_read_q  <= 1'b0;
      ack_write_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      data_out_q  <= data_out_d;
      ack_read_q  <= ack_read_d;
      ack_write_q <= ack_write_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_val] <= data_val;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (go_err)     state_d = ERR;
        else if (go_rd) state_d = RD_ACK;
        else if (go_wr) state_d = WR_ACK;
      end
      RD_ACK: if (ack_in_read) state_d = RD_RTZ;
      RD_RTZ: if (!ack_in_read && addr_sp && rnw_sp) state_d = IDLE;
      WR_ACK: if (addr_sp && rnw_sp && data_sp) state_d = IDLE;
      ERR:    if (addr_sp && rnw_sp && data_sp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; the write fires only on the IDLE->WR_ACK transition, so a
  // held codeword is written exactly once.
  always_comb begin
    data_out_d  = data_out_q;
    ack_read_d  = ack_read_q;
    ack_write_d = ack_write_q;
    error_d     = error_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_err) begin
          error_d = 1'b1;
        end else if (go_rd) begin
          data_out_d = rd_enc;
          ack_read_d = 1'b1;
        end else if (go_wr) begin
          mem_we      = 1'b1;
          ack_write_d = 1'b1;
        end
      end
      RD_ACK: if (ack_in_read) data_out_d = '0;
      RD_RTZ: if (!ack_in_read && addr_sp && rnw_sp) ack_read_d = 1'b0;
      WR_ACK: if (addr_sp && rnw_sp && data_sp) ack_write_d = 1'b0;
      ERR: begin
        data_out_d  = '0;
        ack_read_d  = 1'b0;
        ack_write_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign data_out  = data_out_q;
  assign ack_read  = ack_read_q;
  assign ack_write = ack_write_q;
  assign error     = error_q;
endmodule

// File: tb/tb_dr_memory.sv
// Scoreboard bench for dr_memory: stimulus pushes the expected output tuple
// and the cycle it should appear in; the monitor pops on every output change.
module tb_dr_memory;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic [1:0]  read_Nwrite;
  logic [15:0] data_in;
  logic        ack_in_read;
  logic [15:0] data_out;
  logic        ack_read, ack_write, error;

  dr_memory #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .read_Nwrite(read_Nwrite),
    .data_in(data_in), .ack_in_read(ack_in_read), .data_out(data_out),
    .ack_read(ack_read), .ack_write(ack_write), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] d;
    logic        ar;
    logic        aw;
    logic        er;
  } obs_t;

  obs_t exp_q[$];
  int   cyc_q[$];
  int   compared = 0;
  int   mismatched = 0;
  logic mon_en = 1'b0;
  obs_t prev;
  logic err_exp = 1'b0;

  task automatic expect_at(input logic [15:0] d, input logic ar, input logic aw, input int dly);
    obs_t o;
    o.d = d; o.ar = ar; o.aw = aw; o.er = err_exp;
    exp_q.push_back(o);
    cyc_q.push_back(cyc + dly);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every observed change of outputs must match the next expectation
  always @(negedge clk) begin
    obs_t cur, e;
    int   c;
    if (mon_en) begin
      cur = {data_out, ack_read, ack_write, error};
      if (cur !== prev) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_change cyc=%0d got d=%h ar=%b aw=%b er=%b",
                   cyc, cur.d, cur.ar, cur.aw, cur.er);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          if (cur !== e || cyc != c) begin
            mismatched++;
            $display("FAIL out_change got d=%h ar=%b aw=%b er=%b @%0d want d=%h ar=%b aw=%b er=%b @%0d",
                     cur.d, cur.ar, cur.aw, cur.er, cyc, e.d, e.ar, e.aw, e.er, c);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic idle_inputs();
    addr = 8'h00; read_Nwrite = 2'b00; data_in = 16'h0000; ack_in_read = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    addr = a; read_Nwrite = 2'b01; data_in = d;
    expect_at(16'h0000, 1'b0, 1'b1, 3);
    step(4);
    idle_inputs();
    expect_at(16'h0000, 1'b0, 1'b0, 3);
    step(4);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [15:0] d);
    addr = a; read_Nwrite = 2'b10;
    expect_at(d, 1'b1, 1'b0, 3);
    step(4);
    ack_in_read = 1'b1;
    expect_at(16'h0000, 1'b1, 1'b0, 1);
    step(2);
    idle_inputs();
    expect_at(16'h0000, 1'b0, 1'b0, 3);
    step(4);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    step(3);
    rst_n = 1'b1;
    // Reset state
    compared++;
    if ({data_out, ack_read, ack_write, error} !== 19'h0) begin
      mismatched++;
      $display("FAIL reset_state got d=%h ar=%b aw=%b er=%b want all 0",
               data_out, ack_read, ack_write, error);
    end
    prev = {data_out, ack_read, ack_write, error};
    mon_en = 1'b1;
    step(2);

    // Write 8'hA5 to word 5, read it back, read untouched word 0
    do_write(8'h66, 16'h9966);
    do_read(8'h66, 16'h9966);
    do_read(8'h55, 16'h5555);

    // Illegal operation select: error only, then spacer back to IDLE
    read_Nwrite = 2'b11;
    err_exp = 1'b1;
    expect_at(16'h0000, 1'b0, 1'b0, 3);
    step(4);
    idle_inputs();
    step(4);
    do_read(8'h66, 16'h9966);

    // Partial write to word 3 is ignored until pair 0 completes
    addr = 8'h5A; read_Nwrite = 2'b01; data_in = 16'h9960;
    step(20);
    data_in = 16'h9966;
    expect_at(16'h0000, 1'b0, 1'b1, 3);
    step(4);
    idle_inputs();
    expect_at(16'h0000, 1'b0, 1'b0, 3);
    step(4);
    do_read(8'h5A, 16'h9966);

    // Reset in RD_ACK: immediate clear, codeword still present re-accepted
    addr = 8'h66; read_Nwrite = 2'b10;
    expect_at(16'h9966, 1'b1, 1'b0, 3);
    step(4);
    err_exp = 1'b0;
    expect_at(16'h0000, 1'b0, 1'b0, 1);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({data_out, ack_read, ack_write, error} !== 19'h0) begin
      mismatched++;
      $display("FAIL async_reset got d=%h ar=%b aw=%b er=%b want all 0",
               data_out, ack_read, ack_write, error);
    end
    step(1);
    rst_n = 1'b1;
    expect_at(16'h5555, 1'b1, 1'b0, 3);
    step(4);
    ack_in_read = 1'b1;
    expect_at(16'h0000, 1'b1, 1'b0, 1);
    step(2);
    idle_inputs();
    expect_at(16'h0000, 1'b0, 1'b0, 3);
    step(6);

    while (exp_q.size() != 0) begin
      obs_t e;
      e = exp_q.pop_front();
      void'(cyc_q.pop_front());
      compared++;
      mismatched++;
      $display("FAIL missing_change got none want d=%h ar=%b aw=%b er=%b",
               e.d, e.ar, e.aw, e.er);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
